// File: rtl/cop0_regfile.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : cop0_regfile                                                  |
// | Brief    : CP0 register file (MFC0/MTC0, exception/ERET commit, timer,   |
// |            interrupt sampling). Count/Compare timer built only when      |
// |            COP0_TIMER_EN is defined.                                     |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module cop0_regfile #(
   parameter logic [31:0] PRID_VALUE    = 32'h0001_8000,
   parameter logic [31:0] CONFIG_VALUE  = 32'h8000_0000,
   parameter logic [31:0] CONFIG1_VALUE = 32'h0000_0000,
   parameter int          COUNT_DIV     = 2,
   parameter int          NUM_HW_INT    = 6
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic [4:0]            mf_rd,
   input  logic [2:0]            mf_sel,
   output logic [31:0]           mf_rdata,
   output logic                  mf_invalid,
   input  logic                  mt_valid,
   input  logic [4:0]            mt_rd,
   input  logic [2:0]            mt_sel,
   input  logic [31:0]           mt_wdata,
   input  logic                  ex_valid,
   input  logic [4:0]            ex_code,
   input  logic [31:0]           ex_pc,
   input  logic                  ex_bd,
   input  logic                  ex_bad_valid,
   input  logic [31:0]           ex_badvaddr,
   input  logic                  eret,
   input  logic [NUM_HW_INT-1:0] hw_int,
   output logic [31:0]           epc_o,
   output logic                  exl_o,
   output logic                  int_pending
);

   localparam logic [7:0]  c_SEL_BADVADDR = {5'd8,  3'd0};
   localparam logic [7:0]  c_SEL_COUNT    = {5'd9,  3'd0};
   localparam logic [7:0]  c_SEL_COMPARE  = {5'd11, 3'd0};
   localparam logic [7:0]  c_SEL_STATUS   = {5'd12, 3'd0};
   localparam logic [7:0]  c_SEL_CAUSE    = {5'd13, 3'd0};
   localparam logic [7:0]  c_SEL_EPC      = {5'd14, 3'd0};
   localparam logic [7:0]  c_SEL_PRID     = {5'd15, 3'd0};
   localparam logic [7:0]  c_SEL_CONFIG   = {5'd16, 3'd0};
   localparam logic [7:0]  c_SEL_CONFIG1  = {5'd16, 3'd1};
   localparam logic [7:0]  c_SEL_ERROREPC = {5'd30, 3'd0};

   localparam logic [31:0] c_STATUS_RESET = 32'h0040_0000;
   localparam logic [31:0] c_STATUS_MASK  = 32'h0000_FF03;

   if ((COUNT_DIV < 1) || (NUM_HW_INT < 1) || (NUM_HW_INT > 6)) begin : g_param_check
      $error("cop0_regfile: COUNT_DIV must be >= 1 and NUM_HW_INT in 1..6");
   end

   logic [7:0]            w_mf_sel;
   logic [7:0]            w_mt_sel;
   logic                  w_do_mt;
   logic                  w_wr_status;
   logic                  w_wr_cause;
   logic                  w_wr_epc;
   logic                  w_wr_errorepc;

   logic [31:0]           r_status;
   logic                  r_cause_bd;
   logic [4:0]            r_exc_code;
   logic [1:0]            r_ip_sw;
   logic [NUM_HW_INT-1:0] r_hw_ip;
   logic [31:0]           r_epc;
   logic [31:0]           r_badvaddr;
   logic [31:0]           r_errorepc;

   logic [31:0]           w_count_val;
   logic [31:0]           w_compare_val;
   logic                  w_ti;
   logic [7:0]            w_ip;
   logic [31:0]           w_cause;

   assign w_mf_sel = {mf_rd, mf_sel};
   assign w_mt_sel = {mt_rd, mt_sel};

   // Exception and ERET commits take precedence; a coincident MTC0 is dropped.
   assign w_do_mt       = mt_valid & ~ex_valid & ~eret;
   assign w_wr_status   = w_do_mt & (w_mt_sel == c_SEL_STATUS);
   assign w_wr_cause    = w_do_mt & (w_mt_sel == c_SEL_CAUSE);
   assign w_wr_epc      = w_do_mt & (w_mt_sel == c_SEL_EPC);
   assign w_wr_errorepc = w_do_mt & (w_mt_sel == c_SEL_ERROREPC);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_status <= c_STATUS_RESET;
      end else if (ex_valid) begin
         r_status[1] <= 1'b1;
      end else if (eret) begin
         r_status[1] <= 1'b0;
      end else if (w_wr_status) begin
         r_status <= (r_status & ~c_STATUS_MASK) | (mt_wdata & c_STATUS_MASK);
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_cause_bd <= 1'b0;
         r_exc_code <= 5'd0;
         r_ip_sw    <= 2'b00;
         r_hw_ip    <= '0;
         r_epc      <= 32'h0;
         r_badvaddr <= 32'h0;
         r_errorepc <= 32'h0;
      end else begin
         r_hw_ip <= hw_int;
         if (ex_valid) begin
            r_exc_code <= ex_code;
            // A nested exception keeps the original return point.
            if (!r_status[1]) begin
               r_epc      <= ex_bd ? (ex_pc - 32'd4) : ex_pc;
               r_cause_bd <= ex_bd;
            end
            if (ex_bad_valid) begin
               r_badvaddr <= ex_badvaddr;
            end
         end
         if (w_wr_cause) begin
            r_ip_sw <= mt_wdata[9:8];
         end
         if (w_wr_epc) begin
            r_epc <= mt_wdata;
         end
         if (w_wr_errorepc) begin
            r_errorepc <= mt_wdata;
         end
      end
   end

`ifdef COP0_TIMER_EN
   localparam int c_DIV_W = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;

   logic               w_wr_count;
   logic               w_wr_compare;
   logic               w_div_wrap;
   logic [c_DIV_W-1:0] r_div;
   logic [31:0]        r_count;
   logic [31:0]        r_compare;
   logic               r_count_chg;
   logic               r_ti;

   assign w_wr_count   = w_do_mt & (w_mt_sel == c_SEL_COUNT);
   assign w_wr_compare = w_do_mt & (w_mt_sel == c_SEL_COMPARE);
   assign w_div_wrap   = (r_div == c_DIV_W'(COUNT_DIV - 1));

   // r_count_chg marks a fresh Count value so the match is taken one cycle later
   // and a static Count==Compare (e.g. both zero after reset) never fires.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_div       <= '0;
         r_count     <= 32'h0;
         r_compare   <= 32'h0;
         r_count_chg <= 1'b0;
         r_ti        <= 1'b0;
      end else begin
         r_count_chg <= 1'b0;
         if (w_wr_count) begin
            r_count     <= mt_wdata;
            r_div       <= '0;
            r_count_chg <= 1'b1;
         end else if (w_div_wrap) begin
            r_count     <= r_count + 32'd1;
            r_div       <= '0;
            r_count_chg <= 1'b1;
         end else begin
            r_div <= r_div + c_DIV_W'(1);
         end
         if (w_wr_compare) begin
            r_compare <= mt_wdata;
            r_ti      <= 1'b0;
         end else if (r_count_chg && (r_count == r_compare)) begin
            r_ti <= 1'b1;
         end
      end
   end

   assign w_count_val   = r_count;
   assign w_compare_val = r_compare;
   assign w_ti          = r_ti;
`else
   assign w_count_val   = 32'h0;
   assign w_compare_val = 32'h0;
   assign w_ti          = 1'b0;
`endif

   always_comb begin
      w_ip                   = 8'h00;
      w_ip[1:0]              = r_ip_sw;
      w_ip[2 +: NUM_HW_INT]  = r_hw_ip;
      w_ip[7]                = w_ip[7] | w_ti;
      w_cause                = 32'h0;
      w_cause[31]            = r_cause_bd;
      w_cause[30]            = w_ti;
      w_cause[15:8]          = w_ip;
      w_cause[6:2]           = r_exc_code;
   end

   always_comb begin
      mf_rdata   = 32'h0;
      mf_invalid = 1'b0;
      case (w_mf_sel)
         c_SEL_BADVADDR: mf_rdata = r_badvaddr;
         c_SEL_COUNT:    mf_rdata = w_count_val;
         c_SEL_COMPARE:  mf_rdata = w_compare_val;
         c_SEL_STATUS:   mf_rdata = r_status;
         c_SEL_CAUSE:    mf_rdata = w_cause;
         c_SEL_EPC:      mf_rdata = r_epc;
         c_SEL_PRID:     mf_rdata = PRID_VALUE;
         c_SEL_CONFIG:   mf_rdata = CONFIG_VALUE;
         c_SEL_CONFIG1:  mf_rdata = CONFIG1_VALUE;
         c_SEL_ERROREPC: mf_rdata = r_errorepc;
         default:        mf_invalid = 1'b1;
      endcase
   end

   assign epc_o       = r_epc;
   assign exl_o       = r_status[1];
   assign int_pending = r_status[0] & ~r_status[1] & (|(w_ip & r_status[15:8]));

endmodule
`default_nettype wire

// File: tb/tb_cop0_regfile.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_cop0_regfile                                               |
// | Brief    : directed self-checking bench for cop0_regfile                 |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_cop0_regfile;

   logic        clk;
   logic        resetn;
   logic [4:0]  mf_rd;
   logic [2:0]  mf_sel;
   logic [31:0] mf_rdata;
   logic        mf_invalid;
   logic        mt_valid;
   logic [4:0]  mt_rd;
   logic [2:0]  mt_sel;
   logic [31:0] mt_wdata;
   logic        ex_valid;
   logic [4:0]  ex_code;
   logic [31:0] ex_pc;
   logic        ex_bd;
   logic        ex_bad_valid;
   logic [31:0] ex_badvaddr;
   logic        eret;
   logic [5:0]  hw_int;
   logic [31:0] epc_o;
   logic        exl_o;
   logic        int_pending;

   int vectors;
   int miscompares;

   cop0_regfile dut (
      .clk          (clk),
      .resetn       (resetn),
      .mf_rd        (mf_rd),
      .mf_sel       (mf_sel),
      .mf_rdata     (mf_rdata),
      .mf_invalid   (mf_invalid),
      .mt_valid     (mt_valid),
      .mt_rd        (mt_rd),
      .mt_sel       (mt_sel),
      .mt_wdata     (mt_wdata),
      .ex_valid     (ex_valid),
      .ex_code      (ex_code),
      .ex_pc        (ex_pc),
      .ex_bd        (ex_bd),
      .ex_bad_valid (ex_bad_valid),
      .ex_badvaddr  (ex_badvaddr),
      .eret         (eret),
      .hw_int       (hw_int),
      .epc_o        (epc_o),
      .exl_o        (exl_o),
      .int_pending  (int_pending)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   task automatic rd_sel(input logic [4:0] r, input logic [2:0] s);
      mf_rd  = r;
      mf_sel = s;
      #1;
   endtask

   // Drives one MTC0 that lands on the next rising edge.
   task automatic mtc0(input logic [4:0] r, input logic [2:0] s, input logic [31:0] d);
      mt_valid = 1'b1;
      mt_rd    = r;
      mt_sel   = s;
      mt_wdata = d;
      @(posedge clk);
      #1;
      mt_valid = 1'b0;
   endtask

   task automatic test_reset;
      logic [4:0]  rds  [10] = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd16, 5'd16, 5'd30};
      logic [2:0]  sels [10] = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd1, 3'd0};
      logic [31:0] exps [10] = '{32'h0, 32'h0, 32'h0, 32'h0040_0000, 32'h0, 32'h0,
                                 32'h0001_8000, 32'h8000_0000, 32'h0, 32'h0};
      resetn = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      for (int i = 0; i < 10; i++) begin
         rd_sel(rds[i], sels[i]);
         vectors++;
         if (mf_rdata !== exps[i] || mf_invalid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_read rd=%0d sel=%0d got %h inv=%b want %h inv=0",
                     rds[i], sels[i], mf_rdata, mf_invalid, exps[i]);
         end
      end
      rd_sel(5'd3, 3'd0);
      vectors++;
      if (mf_invalid !== 1'b1 || mf_rdata !== 32'h0) begin
         miscompares++;
         $display("FAIL invalid_sel got inv=%b data=%h want inv=1 data=0", mf_invalid, mf_rdata);
      end
      vectors++;
      if (epc_o !== 32'h0 || exl_o !== 1'b0 || int_pending !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_outputs got epc=%h exl=%b ip=%b want 0/0/0", epc_o, exl_o, int_pending);
      end
      @(posedge clk);
      #1;
      resetn = 1'b1;
   endtask

   task automatic test_write_masks;
      // Same-cycle read shows the pre-edge value.
      mt_valid = 1'b1; mt_rd = 5'd12; mt_sel = 3'd0; mt_wdata = 32'hFFFF_FFFF;
      rd_sel(5'd12, 3'd0);
      vectors++;
      if (mf_rdata !== 32'h0040_0000) begin
         miscompares++;
         $display("FAIL no_bypass got %h want 00400000", mf_rdata);
      end
      @(posedge clk);
      #1;
      mt_valid = 1'b0;
      rd_sel(5'd12, 3'd0);
      vectors++;
      if (mf_rdata !== 32'h0040_FF03) begin
         miscompares++;
         $display("FAIL status_mask got %h want 0040ff03", mf_rdata);
      end
      mtc0(5'd15, 3'd0, 32'h0000_1234);
      rd_sel(5'd15, 3'd0);
      vectors++;
      if (mf_rdata !== 32'h0001_8000) begin
         miscompares++;
         $display("FAIL prid_readonly got %h want 00018000", mf_rdata);
      end
      mtc0(5'd13, 3'd0, 32'hFFFF_FFFF);
      rd_sel(5'd13, 3'd0);
      vectors++;
      if (mf_rdata !== 32'h0000_0300 || int_pending !== 1'b0) begin
         miscompares++;
         $display("FAIL cause_mask got %h ip=%b want 00000300 ip=0", mf_rdata, int_pending);
      end
      mtc0(5'd12, 3'd0, 32'h0000_0301);
      vectors++;
      if (int_pending !== 1'b1) begin
         miscompares++;
         $display("FAIL sw_int_pending got %b want 1", int_pending);
      end
      mtc0(5'd13, 3'd0, 32'h0);
      mtc0(5'd12, 3'd0, 32'h0);
      rd_sel(5'd12, 3'd0);
      vectors++;
      if (mf_rdata !== 32'h0040_0000 || int_pending !== 1'b0) begin
         miscompares++;
         $display("FAIL status_clear got %h ip=%b want 00400000 ip=0", mf_rdata, int_pending);
      end
   endtask

   task automatic test_timer;
`ifdef COP0_TIMER_EN
      mtc0(5'd9, 3'd0, 32'd0);
      mtc0(5'd11, 3'd0, 32'd10);
      // Count=0 lands at edge E0, Compare at E1; Count hits 10 at E20, TI at E21.
      repeat (19) @(posedge clk);
      #1;
      rd_sel(5'd13, 3'd0);
      vectors++;
      if (mf_rdata[30] !== 1'b0) begin
         miscompares++;
         $display("FAIL ti_early got %b want 0", mf_rdata[30]);
      end
      @(posedge clk);
      #1;
      rd_sel(5'd13, 3'd0);
      vectors++;
      if (mf_rdata[30] !== 1'b1 || mf_rdata[15] !== 1'b1) begin
         miscompares++;
         $display("FAIL ti_set got ti=%b ip7=%b want 1/1", mf_rdata[30], mf_rdata[15]);
      end
      rd_sel(5'd9, 3'd0);
      vectors++;
      if (mf_rdata !== 32'd10) begin
         miscompares++;
         $display("FAIL count_value got %0d want 10", mf_rdata);
      end
      mtc0(5'd12, 3'd0, 32'h0000_8001);
      vectors++;
      if (int_pending !== 1'b1) begin
         miscompares++;
         $display("FAIL timer_int_pending got %b want 1", int_pending);
      end
      mtc0(5'd11, 3'd0, 32'hFFFF_0000);
      rd_sel(5'd13, 3'd0);
      vectors++;
      if (mf_rdata[30] !== 1'b0 || int_pending !== 1'b0) begin
         miscompares++;
         $display("FAIL ti_clear got ti=%b ip=%b want 0/0", mf_rdata[30], int_pending);
      end
      mtc0(5'd12, 3'd0, 32'h0);
`else
      mtc0(5'd9, 3'd0, 32'd5);
      mtc0(5'd11, 3'd0, 32'd7);
      rd_sel(5'd9, 3'd0);
      vectors++;
      if (mf_rdata !== 32'h0) begin
         miscompares++;
         $display("FAIL count_absent got %h want 0", mf_rdata);
      end
      rd_sel(5'd11, 3'd0);
      vectors++;
      if (mf_rdata !== 32'h0) begin
         miscompares++;
         $display("FAIL compare_absent got %h want 0", mf_rdata);
      end
`endif
   endtask

   task automatic test_exception;
      ex_valid = 1'b1; ex_pc = 32'h8000_0100; ex_bd = 1'b1; ex_code = 5'd4;
      ex_bad_valid = 1'b1; ex_badvaddr = 32'hDEAD_BEEF;
      @(posedge clk);
      #1;
      ex_valid = 1'b0; ex_bad_valid = 1'b0;
      rd_sel(5'd13, 3'd0);
      vectors++;
      if (epc_o !== 32'h8000_00FC || exl_o !== 1'b1 || mf_rdata !== 32'h8000_0010) begin
         miscompares++;
         $display("FAIL exc_first got epc=%h exl=%b cause=%h want 800000fc/1/80000010",
                  epc_o, exl_o, mf_rdata);
      end
      rd_sel(5'd8, 3'd0);
      vectors++;
      if (mf_rdata !== 32'hDEAD_BEEF) begin
         miscompares++;
         $display("FAIL badvaddr got %h want deadbeef", mf_rdata);
      end
      ex_valid = 1'b1; ex_pc = 32'h0000_0200; ex_bd = 1'b0; ex_code = 5'd5;
      @(posedge clk);
      #1;
      ex_valid = 1'b0;
      rd_sel(5'd13, 3'd0);
      vectors++;
      if (epc_o !== 32'h8000_00FC || mf_rdata !== 32'h8000_0014) begin
         miscompares++;
         $display("FAIL exc_nested got epc=%h cause=%h want 800000fc/80000014", epc_o, mf_rdata);
      end
      rd_sel(5'd8, 3'd0);
      vectors++;
      if (mf_rdata !== 32'hDEAD_BEEF) begin
         miscompares++;
         $display("FAIL badvaddr_hold got %h want deadbeef", mf_rdata);
      end
      eret = 1'b1;
      @(posedge clk);
      #1;
      eret = 1'b0;
      vectors++;
      if (exl_o !== 1'b0) begin
         miscompares++;
         $display("FAIL eret got exl=%b want 0", exl_o);
      end
   endtask

   task automatic test_priority;
      ex_valid = 1'b1; ex_pc = 32'h0000_0300; ex_bd = 1'b0; ex_code = 5'd8;
      mt_valid = 1'b1; mt_rd = 5'd14; mt_sel = 3'd0; mt_wdata = 32'h0000_0055;
      @(posedge clk);
      #1;
      ex_valid = 1'b0; mt_valid = 1'b0;
      vectors++;
      if (epc_o !== 32'h0000_0300 || exl_o !== 1'b1) begin
         miscompares++;
         $display("FAIL ex_over_mt got epc=%h exl=%b want 00000300/1", epc_o, exl_o);
      end
      eret = 1'b1;
      mt_valid = 1'b1; mt_rd = 5'd14; mt_sel = 3'd0; mt_wdata = 32'h0000_0077;
      @(posedge clk);
      #1;
      eret = 1'b0; mt_valid = 1'b0;
      vectors++;
      if (epc_o !== 32'h0000_0300 || exl_o !== 1'b0) begin
         miscompares++;
         $display("FAIL eret_over_mt got epc=%h exl=%b want 00000300/0", epc_o, exl_o);
      end
   endtask

   task automatic test_hw_int;
      mtc0(5'd12, 3'd0, 32'h0000_0401);
      hw_int = 6'b000001;
      rd_sel(5'd13, 3'd0);
      vectors++;
      if (mf_rdata[10] !== 1'b0 || int_pending !== 1'b0) begin
         miscompares++;
         $display("FAIL hw_sample_early got ip2=%b ip=%b want 0/0", mf_rdata[10], int_pending);
      end
      @(posedge clk);
      #1;
      rd_sel(5'd13, 3'd0);
      vectors++;
      if (mf_rdata[10] !== 1'b1 || int_pending !== 1'b1) begin
         miscompares++;
         $display("FAIL hw_sample got ip2=%b ip=%b want 1/1", mf_rdata[10], int_pending);
      end
      #3;
      resetn = 1'b0;
      #2;
      rd_sel(5'd13, 3'd0);
      vectors++;
      if (mf_rdata !== 32'h0 || epc_o !== 32'h0 || exl_o !== 1'b0 || int_pending !== 1'b0) begin
         miscompares++;
         $display("FAIL async_reset got cause=%h epc=%h exl=%b ip=%b want 0/0/0/0",
                  mf_rdata, epc_o, exl_o, int_pending);
      end
      rd_sel(5'd12, 3'd0);
      vectors++;
      if (mf_rdata !== 32'h0040_0000) begin
         miscompares++;
         $display("FAIL reset_status got %h want 00400000", mf_rdata);
      end
      hw_int = 6'b0;
      @(posedge clk);
      #1;
      resetn = 1'b1;
   endtask

   initial begin
      vectors = 0;
      miscompares = 0;
      resetn = 1'b0;
      mf_rd = 5'd0; mf_sel = 3'd0;
      mt_valid = 1'b0; mt_rd = 5'd0; mt_sel = 3'd0; mt_wdata = 32'h0;
      ex_valid = 1'b0; ex_code = 5'd0; ex_pc = 32'h0; ex_bd = 1'b0;
      ex_bad_valid = 1'b0; ex_badvaddr = 32'h0; eret = 1'b0; hw_int = 6'b0;
      test_reset();
      test_write_masks();
      test_timer();
      test_exception();
      test_priority();
      test_hw_int();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
